// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the two byte sources, the UART transmitter and the arbiter.
// The arbiter connects through the slave modport; the environment uses master.
interface uart_tx_arbiter_if #(
    parameter int DATA_W = 8
);
    logic              req0_valid;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;
    logic              req1_valid;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;
    logic              tx_start;
    logic [DATA_W-1:0] tx_data;
    logic              tx_parity;
    logic              tx_done;
    logic [1:0]        grant;
    logic              timeout_err;

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data, tx_done,
        input  req0_ready, req1_ready, tx_start, tx_data, tx_parity, grant, timeout_err
    );

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data, tx_done,
        output req0_ready, req1_ready, tx_start, tx_data, tx_parity, grant, timeout_err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between the switch byte and the Rx echo,
// with a one-entry holding buffer per source, a completion timeout and parity generation.
module uart_tx_arbiter #(
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 2048,
    parameter bit PARITY_ODD     = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    uart_tx_arbiter_if.slave bus
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              buf0_full;
    logic              buf1_full;
    logic [DATA_W-1:0] buf0_data;
    logic [DATA_W-1:0] buf1_data;
    logic              last_grant;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] tx_data_q;
    logic              tx_parity_q;
    logic [1:0]        grant_q;
    logic              timeout_q;
    logic              accept0;
    logic              accept1;
    logic              pick1;
    logic              launch;
    logic              finish;
    logic              expire;
    logic [DATA_W-1:0] sel_data;

    assign bus.req0_ready  = ~buf0_full & ~rst;
    assign bus.req1_ready  = ~buf1_full & ~rst;
    assign bus.tx_start    = (state == LAUNCH);
    assign bus.tx_data     = tx_data_q;
    assign bus.tx_parity   = tx_parity_q;
    assign bus.grant       = grant_q;
    assign bus.timeout_err = timeout_q;

    assign accept0  = bus.req0_valid & bus.req0_ready;
    assign accept1  = bus.req1_valid & bus.req1_ready;
    // On a tie the source that did not own the last grant wins; last_grant=1 means source 1.
    assign pick1    = buf1_full & (~buf0_full | ~last_grant);
    assign sel_data = pick1 ? buf1_data : buf0_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        launch     = 1'b0;
        finish     = 1'b0;
        expire     = 1'b0;
        case (state)
            IDLE: begin
                if (buf0_full | buf1_full) begin
                    launch     = 1'b1;
                    state_next = LAUNCH;
                end
            end
            LAUNCH: begin
                state_next = WAIT_DONE;
            end
            WAIT_DONE: begin
                // Completion takes priority over a timeout landing in the same cycle.
                if (bus.tx_done) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end else if (count == CNT_LAST) begin
                    expire     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf0_full   <= 1'b0;
            buf1_full   <= 1'b0;
            buf0_data   <= '0;
            buf1_data   <= '0;
            last_grant  <= 1'b1;
            count       <= '0;
            tx_data_q   <= '0;
            tx_parity_q <= 1'b0;
            grant_q     <= 2'b00;
            timeout_q   <= 1'b0;
        end else begin
            if (accept0) begin
                buf0_full <= 1'b1;
                buf0_data <= bus.req0_data;
            end else if (launch && !pick1) begin
                buf0_full <= 1'b0;
            end

            if (accept1) begin
                buf1_full <= 1'b1;
                buf1_data <= bus.req1_data;
            end else if (launch && pick1) begin
                buf1_full <= 1'b0;
            end

            if (launch) begin
                tx_data_q   <= sel_data;
                tx_parity_q <= (^sel_data) ^ PARITY_ODD;
                grant_q     <= pick1 ? 2'b10 : 2'b01;
                last_grant  <= pick1;
            end else if (finish || expire) begin
                grant_q <= 2'b00;
            end

            if (expire) begin
                timeout_q <= 1'b1;
            end

            // Saturating wait counter, restarted on every launch.
            if (state == LAUNCH) begin
                count <= '0;
            end else if (state == WAIT_DONE && count != CNT_LAST) begin
                count <= count + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: an even-parity and an odd-parity instance share one stimulus
// stream and are compared every cycle against a transfer-level model plus directed checks.
module tb_uart_tx_arbiter;
    localparam int DW  = 8;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid;
    logic [DW-1:0] req0_data;
    logic          req1_valid;
    logic [DW-1:0] req1_data;
    logic          tx_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.DATA_W(DW)) ifa ();
    uart_tx_arbiter_if #(.DATA_W(DW)) ifb ();

    assign ifa.req0_valid = req0_valid;
    assign ifa.req0_data  = req0_data;
    assign ifa.req1_valid = req1_valid;
    assign ifa.req1_data  = req1_data;
    assign ifa.tx_done    = tx_done;
    assign ifb.req0_valid = req0_valid;
    assign ifb.req0_data  = req0_data;
    assign ifb.req1_valid = req1_valid;
    assign ifb.req1_data  = req1_data;
    assign ifb.tx_done    = tx_done;

    uart_tx_arbiter #(.DATA_W(DW), .TIMEOUT_CYCLES(TMO), .PARITY_ODD(1'b0)) dut_even (
        .clk(clk), .rst(rst), .bus(ifa)
    );

    uart_tx_arbiter #(.DATA_W(DW), .TIMEOUT_CYCLES(TMO), .PARITY_ODD(1'b1)) dut_odd (
        .clk(clk), .rst(rst), .bus(ifb)
    );

    // Transfer-level model: holding slots, current owner and the phase of the current transfer.
    bit            m_on = 1'b0;
    bit            m_full [2];
    logic [DW-1:0] m_buf  [2];
    int            m_last;
    int            m_owner;
    int            m_phase;
    int            m_wait;
    logic [DW-1:0] m_cur;
    bit            m_loaded;
    bit            m_err;

    initial begin
        int  w;
        bit  take0;
        bit  take1;
        forever begin
            @(posedge clk);
            if (rst === 1'b1) begin
                m_on = 1'b1; m_full[0] = 1'b0; m_full[1] = 1'b0;
                m_buf[0] = '0; m_buf[1] = '0; m_last = 1; m_owner = 0;
                m_phase = 0; m_wait = 0; m_cur = '0; m_loaded = 1'b0; m_err = 1'b0;
            end else if (m_on) begin
                take0 = (req0_valid === 1'b1) && !m_full[0];
                take1 = (req1_valid === 1'b1) && !m_full[1];
                if (m_phase == 0) begin
                    if (m_full[0] || m_full[1]) begin
                        if (m_full[0] && m_full[1]) w = 1 - m_last;
                        else                        w = m_full[1] ? 1 : 0;
                        m_cur = m_buf[w]; m_loaded = 1'b1; m_full[w] = 1'b0;
                        m_owner = w + 1; m_last = w; m_phase = 1;
                    end
                end else if (m_phase == 1) begin
                    m_phase = 2; m_wait = 0;
                end else begin
                    if (tx_done === 1'b1) begin
                        m_phase = 0; m_owner = 0;
                    end else if (m_wait == TMO - 1) begin
                        m_phase = 0; m_owner = 0; m_err = 1'b1;
                    end else begin
                        m_wait = m_wait + 1;
                    end
                end
                if (take0) begin m_full[0] = 1'b1; m_buf[0] = req0_data; end
                if (take1) begin m_full[1] = 1'b1; m_buf[1] = req1_data; end
            end
        end
    end

    task automatic compareOne(input string tag, input logic r0, input logic r1, input logic st,
                              input logic [DW-1:0] d, input logic p, input logic [1:0] g,
                              input logic e, input logic odd);
        logic          er0, er1, est, ep, ee;
        logic [1:0]    eg;
        logic [DW-1:0] ed;
        er0 = !m_full[0] && (rst !== 1'b1);
        er1 = !m_full[1] && (rst !== 1'b1);
        est = (m_phase == 1);
        ed  = m_cur;
        ep  = m_loaded ? ((^m_cur) ^ odd) : 1'b0;
        eg  = (m_owner == 1) ? 2'b01 : ((m_owner == 2) ? 2'b10 : 2'b00);
        ee  = m_err;
        checks++;
        if ({r0, r1, st, d, p, g, e} !== {er0, er1, est, ed, ep, eg, ee}) begin
            errors++;
            $display("[TB] FAIL model_%s t=%0t got r0=%b r1=%b st=%b d=%h p=%b g=%b e=%b want r0=%b r1=%b st=%b d=%h p=%b g=%b e=%b",
                     tag, $time, r0, r1, st, d, p, g, e, er0, er1, est, ed, ep, eg, ee);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (m_on) begin
                compareOne("even", ifa.req0_ready, ifa.req1_ready, ifa.tx_start, ifa.tx_data,
                           ifa.tx_parity, ifa.grant, ifa.timeout_err, 1'b0);
                compareOne("odd", ifb.req0_ready, ifb.req1_ready, ifb.tx_start, ifb.tx_data,
                           ifb.tx_parity, ifb.grant, ifb.timeout_err, 1'b1);
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s t=%0t got %h want %h", name, $time, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v0, input logic [DW-1:0] d0, input logic v1,
                                 input logic [DW-1:0] d1, input logic done);
        req0_valid = v0; req0_data = d0;
        req1_valid = v1; req1_data = d1;
        tx_done    = done;
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic waitStart(input string name, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            if (ifa.tx_start === 1'b1) seen = 1'b1;
            else tick();
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s t=%0t got no tx_start want tx_start within %0d cycles", name, $time, budget);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog t=%0t got no finish want finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [1:0]    gseq  [4];
        logic [DW-1:0] dseq  [4];
        logic [1:0]    g_exp [4];
        logic [DW-1:0] d_exp [4];
        bit            take0, take1;
        int            nst, since, starts;

        g_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
        d_exp = '{8'h10, 8'h20, 8'h11, 8'h21};

        // Reset values
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        rst = 1'b1;
        tick();
        tick();
        checkOutput("reset_grant", 32'(ifa.grant), 32'h0);
        checkOutput("reset_data", 32'(ifa.tx_data), 32'h0);
        checkOutput("reset_err", 32'(ifa.timeout_err), 32'h0);
        checkOutput("reset_start", 32'(ifa.tx_start), 32'h0);
        checkOutput("reset_ready0_in_rst", 32'(ifa.req0_ready), 32'h0);
        checkOutput("reset_parity_odd", 32'(ifb.tx_parity), 32'h0);
        rst = 1'b0;
        tick();
        checkOutput("ready0_after_reset", 32'(ifa.req0_ready), 32'h1);

        // 1: single request, latency two cycles
        applyStimulus(1'b1, 8'h2C, 1'b0, 8'h00, 1'b0);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        checkOutput("t1_ready_drop", 32'(ifa.req0_ready), 32'h0);
        checkOutput("t1_no_early_start", 32'(ifa.tx_start), 32'h0);
        tick();
        checkOutput("t1_start", 32'(ifa.tx_start), 32'h1);
        checkOutput("t1_data", 32'(ifa.tx_data), 32'h2C);
        checkOutput("t1_parity", 32'(ifa.tx_parity), 32'h1);
        checkOutput("t1_grant", 32'(ifa.grant), 32'h1);
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("t1_ready_busy", 32'(ifa.req0_ready), 32'h1);
        end
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        checkOutput("t1_grant_idle", 32'(ifa.grant), 32'h0);

        // 2: tie, source 0 first, then source 1 two cycles after done
        doReset();
        applyStimulus(1'b1, 8'h2C, 1'b1, 8'h55, 1'b0);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        tick();
        checkOutput("t2_first_grant", 32'(ifa.grant), 32'h1);
        checkOutput("t2_first_data", 32'(ifa.tx_data), 32'h2C);
        checkOutput("t2_first_parity", 32'(ifa.tx_parity), 32'h1);
        tick(); tick(); tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        checkOutput("t2_gap_start", 32'(ifa.tx_start), 32'h0);
        tick();
        checkOutput("t2_second_start", 32'(ifa.tx_start), 32'h1);
        checkOutput("t2_second_data", 32'(ifa.tx_data), 32'h55);
        checkOutput("t2_second_parity", 32'(ifa.tx_parity), 32'h0);
        checkOutput("t2_second_parity_odd", 32'(ifb.tx_parity), 32'h1);
        checkOutput("t2_second_grant", 32'(ifa.grant), 32'h2);
        tick(); tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;

        // 3: round robin with both sources always valid, done five cycles after each start
        doReset();
        applyStimulus(1'b1, 8'h10, 1'b1, 8'h20, 1'b0);
        nst = 0;
        since = -1;
        for (int c = 0; c < 200 && !(nst == 4 && since == 5); c++) begin
            take0 = (req0_valid === 1'b1) && (ifa.req0_ready === 1'b1);
            take1 = (req1_valid === 1'b1) && (ifa.req1_ready === 1'b1);
            tick();
            if (take0) req0_data = req0_data + 8'h01;
            if (take1) req1_data = req1_data + 8'h01;
            if (ifa.tx_start === 1'b1) begin
                if (nst < 4) begin
                    gseq[nst] = ifa.grant;
                    dseq[nst] = ifa.tx_data;
                end
                nst++;
                since = 0;
            end else if (since >= 0) begin
                since++;
            end
            tx_done = (since == 5);
        end
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        checkOutput("t3_transfer_count", 32'(nst), 32'd4);
        for (int i = 0; i < 4 && i < nst; i++) begin
            checkOutput($sformatf("t3_grant_%0d", i), 32'(gseq[i]), 32'(g_exp[i]));
            checkOutput($sformatf("t3_data_%0d", i), 32'(dseq[i]), 32'(d_exp[i]));
        end

        // 4: timeout after sixteen cycles in the wait phase
        doReset();
        applyStimulus(1'b0, 8'h00, 1'b1, 8'hA5, 1'b0);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        waitStart("t4_wait_start", 10);
        checkOutput("t4_data", 32'(ifa.tx_data), 32'hA5);
        checkOutput("t4_parity", 32'(ifa.tx_parity), 32'h0);
        checkOutput("t4_grant", 32'(ifa.grant), 32'h2);
        for (int i = 0; i < 16; i++) begin
            tick();
            checkOutput("t4_still_waiting", 32'({ifa.grant, ifa.timeout_err}), 32'b100);
        end
        tick();
        checkOutput("t4_idle_grant", 32'(ifa.grant), 32'h0);
        checkOutput("t4_err_set", 32'(ifa.timeout_err), 32'h1);
        applyStimulus(1'b1, 8'h01, 1'b0, 8'h00, 1'b0);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        tick();
        checkOutput("t4_next_start", 32'(ifa.tx_start), 32'h1);
        checkOutput("t4_next_data", 32'(ifa.tx_data), 32'h01);
        checkOutput("t4_next_parity", 32'(ifa.tx_parity), 32'h1);
        checkOutput("t4_err_sticky", 32'(ifa.timeout_err), 32'h1);

        // 5: reset during the wait phase with buffer 1 holding 0x33
        tick();
        applyStimulus(1'b0, 8'h00, 1'b1, 8'h33, 1'b0);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        checkOutput("t5_buf1_full", 32'(ifa.req1_ready), 32'h0);
        rst = 1'b1;
        #1;
        checkOutput("t5_ready_in_rst", 32'({ifa.req0_ready, ifa.req1_ready}), 32'h0);
        tick();
        rst = 1'b0;
        #1;
        checkOutput("t5_grant", 32'(ifa.grant), 32'h0);
        checkOutput("t5_err_cleared", 32'(ifa.timeout_err), 32'h0);
        checkOutput("t5_ready_after", 32'({ifa.req0_ready, ifa.req1_ready}), 32'b11);
        starts = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (ifa.tx_start === 1'b1) starts++;
        end
        checkOutput("t5_no_start", 32'(starts), 32'h0);

        // 6: backpressure on source 0 and odd parity
        doReset();
        applyStimulus(1'b1, 8'h0F, 1'b0, 8'h00, 1'b0);
        tick();
        applyStimulus(1'b1, 8'hFF, 1'b0, 8'h00, 1'b0);
        checkOutput("t6_ready_full", 32'(ifa.req0_ready), 32'h0);
        tick();
        checkOutput("t6_start", 32'(ifb.tx_start), 32'h1);
        checkOutput("t6_data", 32'(ifb.tx_data), 32'h0F);
        checkOutput("t6_parity_odd", 32'(ifb.tx_parity), 32'h1);
        checkOutput("t6_parity_even", 32'(ifa.tx_parity), 32'h0);
        checkOutput("t6_ready_after_grant", 32'(ifa.req0_ready), 32'h1);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        checkOutput("t6_ff_taken", 32'(ifa.req0_ready), 32'h0);
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        tick();
        checkOutput("t6_ff_start", 32'(ifb.tx_start), 32'h1);
        checkOutput("t6_ff_data", 32'(ifb.tx_data), 32'hFF);
        checkOutput("t6_ff_parity_odd", 32'(ifb.tx_parity), 32'h1);
        tick(); tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single UART transmitter between two byte sources. Source 0 is the switch byte loaded by a debounced button pulse; source 1 is the receiver echo path. Each source gets a one-entry holding buffer. A round-robin scheduler launches one transfer at a time into the transmitter, waits for completion, and aborts on timeout. It also generates the parity bit the transmitter frames with the byte.

Parameters:
DATA_W, 8, byte width of each source and of tx_data
TIMEOUT_CYCLES, 2048, maximum number of cycles spent in WAIT_DONE before the transfer is abandoned; must be at least 2
PARITY_ODD, 0, 0 = even parity (tx_parity = XOR of tx_data); 1 = odd parity (inverted XOR)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
req0_valid  input  1  source 0 (switch) byte valid
req0_data  input  DATA_W  source 0 byte
req0_ready  output  1  source 0 holding buffer empty; transfer accepted when valid && ready
req1_valid  input  1  source 1 (Rx echo) byte valid
req1_data  input  DATA_W  source 1 byte
req1_ready  output  1  source 1 holding buffer empty
tx_start  output  1  one-cycle launch pulse to the transmitter
tx_data  output  DATA_W  byte to transmit; held stable from tx_start until the next grant
tx_parity  output  1  parity of tx_data, registered together with tx_data
tx_done  input  1  one-cycle pulse from the transmitter when the frame (stop bit) completes
grant  output  2  one-hot current owner: 01 = source 0, 10 = source 1, 00 = idle
timeout_err  output  1  sticky flag; set on timeout, cleared only by rst

Behaviour:
- Reset (rst high at a clk edge):
  - state goes to IDLE; both buffers are emptied; tx_start=0, tx_data=0, tx_parity=0, grant=00, timeout_err=0; timeout counter=0.
  - last_grant is set to source 1, so source 0 wins the first tie.
  - reqN_ready = ~bufN_full & ~rst, so both ready outputs are 0 while rst is high.
  - Reset mid-transfer discards any in-flight or buffered bytes. No tx_start is issued afterwards.
- Buffer accept: on valid && ready at edge N, bufN_full=1 and the data is captured. ready drops in cycle N+1. While a buffer is full, its contents are never overwritten.
- State machine: IDLE, LAUNCH, WAIT_DONE.
  - IDLE, no buffer full: stay in IDLE, grant=00.
  - IDLE, one or more buffers full: select a winner.
    - Only one full: that source wins.
    - Both full: the source that is not last_grant wins.
    - On the transition: tx_data and tx_parity load from the winning buffer, that buffer is cleared (its ready returns the next cycle), grant is set to the winner, last_grant is updated, and state goes to LAUNCH.
  - LAUNCH: tx_start=1 for exactly this cycle. tx_done is ignored. Next state is WAIT_DONE and the counter is cleared.
  - WAIT_DONE: the counter increments every cycle.
    - If tx_done=1, go to IDLE and set grant=00.
    - Otherwise, if the counter equals TIMEOUT_CYCLES-1, go to IDLE, set grant=00 and set timeout_err=1.
    - If tx_done and the timeout occur in the same cycle, done wins and timeout_err is not set.
- Latency:
  - A byte accepted at edge N, with the scheduler idle, gives tx_start high in cycle N+2.
  - After tx_done is seen in cycle D, the next queued byte gives tx_start in cycle D+2.
- Back-to-back: a source may refill its buffer while its previous byte is being transmitted.
- Parity: tx_parity = ^tx_data ^ PARITY_ODD.
- Counter width: clog2(TIMEOUT_CYCLES). The counter saturates and does not wrap in WAIT_DONE.

Test Plan:
1. Single request: after reset, req0_valid=1 with 0x2C (switch=44) for one cycle. Required: tx_start pulses exactly 2 cycles later with tx_data=0x2C, tx_parity=1 and grant=01. tx_done 10 cycles later. Required: grant=00 the next cycle and req0_ready=1 throughout the transfer after the grant cycle.
2. Simultaneous tie: after reset, req0=0x2C and req1=0x55 in the same cycle. Required: source 0 is sent first (grant=01, parity 1). After its tx_done, the source 1 tx_start occurs 2 cycles later with tx_data=0x55, tx_parity=0, grant=10.
3. Round robin: both valids held high continuously, with tx_done returned 5 cycles after each tx_start. Required: the grant sequence across 4 transfers is 01, 10, 01, 10 and no byte is lost.
4. Timeout: TIMEOUT_CYCLES=16, req1=0xA5, tx_done never asserted. Required: return to IDLE exactly 16 cycles after entering WAIT_DONE, timeout_err=1. A following req0=0x01 is still served, and timeout_err stays 1.
5. Reset mid-operation: rst pulsed for 1 cycle during WAIT_DONE while buf1 holds 0x33. Required: on the next cycle grant=00, timeout_err=0, both ready=1 after rst falls, and no tx_start occurs for 0x33.
6. Backpressure and PARITY_ODD=1: req0 0x0F is accepted, then req0 0xFF is presented while buf0 is full. Required: req0_ready=0, 0xFF is not taken, the transmitted byte is 0x0F with tx_parity=1. 0xFF is accepted only after the grant.
